gsim_sweep_ctrl: RTL and testbench

//  Sequencer for the GSIM Gauss-Seidel solver datapath (16x16 banded system, coefficients 20/-13/6/-1).
//  - Accepts the 16-word b stream and writes it into the b store.
//  - Schedules row updates on the shared row-update engine, one row at a time and in order, sweep after sweep.
//  - Ends on a sweep cap or on early convergence, then streams the 16 x results out (16.16 fixed point).

---
 rtl/gsim_sweep_ctrl.sv | 258 +++++++++++++++++++++++++
 tb/tb_gsim_sweep_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gsim_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : gsim_sweep_ctrl
// Description : Sequencer for the GSIM Gauss-Seidel solver datapath.
//               Captures the N-word b vector into the b store, issues row
//               updates to the shared row-update engine one row at a time,
//               sweep after sweep, until either the sweep cap is reached or
//               a full sweep reports convergence (after a minimum number of
//               sweeps). It then streams the N x results out of the x store.
//
// Ports       : clk        - clock, rising edge
//               reset      - synchronous, active-high reset
//               in_en/b_in - b word stream, b[0]..b[N-1] in order
//               b_we/b_waddr/b_wdata - b store write port (1-cycle lag)
//               row_start  - one-cycle pulse, engine starts row row_idx
//               row_idx    - row being updated
//               nbr_mask   - valid neighbours, bits 0..5 = -3,-2,-1,+1,+2,+3
//               row_done   - engine finished the current row
//               row_conv   - row converged, sampled with row_done
//               rd_en/rd_addr/rd_data - x store read port (1-cycle latency)
//               out_valid/x_out - result stream x[0]..x[N-1]
//               busy       - high whenever not idle
//               sweep_cnt  - sweeps completed in the current run
//
// Revision    : 1.0 - initial release
// ============================================================================
module gsim_sweep_ctrl #(
    parameter int N        = 16,
    parameter int N_ITER   = 64,
    parameter int MIN_ITER = 8,
    parameter int DW       = 16,
    parameter int XW       = 32,
    parameter int ITW      = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_en,
    input  logic [DW-1:0]  b_in,
    output logic           b_we,
    output logic [3:0]     b_waddr,
    output logic [DW-1:0]  b_wdata,
    output logic           row_start,
    output logic [3:0]     row_idx,
    output logic [5:0]     nbr_mask,
    input  logic           row_done,
    input  logic           row_conv,
    output logic           rd_en,
    output logic [3:0]     rd_addr,
    input  logic [XW-1:0]  rd_data,
    output logic           out_valid,
    output logic [XW-1:0]  x_out,
    output logic           busy,
    output logic [ITW-1:0] sweep_cnt
);

    localparam logic [3:0]     c_ROW_LAST = 4'(N - 1);
    localparam logic [ITW-1:0] c_ITER_MAX = ITW'(N_ITER);
    localparam logic [ITW-1:0] c_ITER_MIN = ITW'(MIN_ITER);
    localparam logic [4:0]     c_RD_END   = 5'(N);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_OUT   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [3:0]      r_load_cnt;
    logic [3:0]      r_row;
    logic [3:0]      w_row_nxt;
    logic [ITW-1:0]  r_sweep;
    logic            r_conv;
    logic [4:0]      r_rd_cnt;
    logic            r_rd_v1;
    logic            r_out_valid;
    logic [XW-1:0]   r_x_out;
    logic            r_b_we;
    logic [3:0]      r_b_waddr;
    logic [DW-1:0]   r_b_wdata;
    logic [3:0]      r_row_idx;
    logic [5:0]      r_nbr_mask;

    logic            w_take;
    logic            w_load_last;
    logic            w_done_row;
    logic            w_row_last;
    logic [ITW-1:0]  w_sweep_inc;
    logic            w_conv_and;
    logic            w_stop;
    logic            w_rd_en;
    logic            w_row_start;
    logic            w_busy;

    // Neighbour d of row r is valid when 0 <= r+d <= N-1. Negative offsets
    // only need a lower bound check, positive ones only an upper bound.
    function automatic logic [5:0] f_mask(input logic [3:0] row);
        int r;
        r         = int'(row);
        f_mask[0] = (r >= 3);
        f_mask[1] = (r >= 2);
        f_mask[2] = (r >= 1);
        f_mask[3] = (r <= N - 2);
        f_mask[4] = (r <= N - 3);
        f_mask[5] = (r <= N - 4);
    endfunction

    // b words are only accepted while loading; anything else is dropped.
    assign w_take      = in_en && ((r_state == S_IDLE) || (r_state == S_LOAD));
    assign w_load_last = w_take && (r_load_cnt == c_ROW_LAST);
    // row_done outside WAIT is ignored.
    assign w_done_row  = (r_state == S_WAIT) && row_done;
    assign w_row_last  = (r_row == c_ROW_LAST);
    assign w_sweep_inc = r_sweep + 1'b1;
    assign w_conv_and  = r_conv & row_conv;
    assign w_stop      = (w_sweep_inc == c_ITER_MAX) ||
                         (w_conv_and && (w_sweep_inc >= c_ITER_MIN));

    // Next-state and state-decoded outputs
    always_comb begin
        w_state_nxt = r_state;
        w_row_nxt   = r_row;
        w_row_start = 1'b0;
        w_rd_en     = 1'b0;
        w_busy      = 1'b1;
        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (w_take) begin
                    w_state_nxt = w_load_last ? S_ISSUE : S_LOAD;
                    w_row_nxt   = 4'd0;
                end
            end
            S_LOAD: begin
                if (w_load_last) begin
                    w_state_nxt = S_ISSUE;
                    w_row_nxt   = 4'd0;
                end
            end
            S_ISSUE: begin
                w_row_start = 1'b1;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (row_done) begin
                    if (!w_row_last) begin
                        w_row_nxt   = r_row + 4'd1;
                        w_state_nxt = S_ISSUE;
                    end else begin
                        w_row_nxt   = 4'd0;
                        w_state_nxt = w_stop ? S_OUT : S_ISSUE;
                    end
                end
            end
            S_OUT: begin
                w_rd_en = (r_rd_cnt < c_RD_END);
                // Last result is on x_out and no read is still in flight.
                if (r_out_valid && !r_rd_v1) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_load_cnt  <= 4'd0;
            r_row       <= 4'd0;
            r_sweep     <= '0;
            r_conv      <= 1'b1;
            r_rd_cnt    <= 5'd0;
            r_rd_v1     <= 1'b0;
            r_out_valid <= 1'b0;
            r_x_out     <= '0;
            r_b_we      <= 1'b0;
            r_b_waddr   <= 4'd0;
            r_b_wdata   <= '0;
            r_row_idx   <= 4'd0;
            r_nbr_mask  <= 6'd0;
        end else begin
            r_state <= w_state_nxt;
            r_row   <= w_row_nxt;

            // b capture: write port lags the input stream by one cycle
            r_b_we <= w_take;
            if (w_take) begin
                r_b_waddr  <= r_load_cnt;
                r_b_wdata  <= b_in;
                r_load_cnt <= r_load_cnt + 4'd1;
            end

            // New run starts with a clean sweep count and convergence flag;
            // sweep_cnt of the previous run stays visible until here.
            if (w_load_last) begin
                r_sweep <= '0;
                r_conv  <= 1'b1;
            end

            if (w_done_row) begin
                if (w_row_last) begin
                    r_sweep <= w_sweep_inc;
                    r_conv  <= w_stop ? w_conv_and : 1'b1;
                end else begin
                    r_conv  <= w_conv_and;
                end
            end

            // Row index and mask are latched on entry to ISSUE and then held
            // for the whole engine transaction.
            if (w_state_nxt == S_ISSUE) begin
                r_row_idx  <= w_row_nxt;
                r_nbr_mask <= f_mask(w_row_nxt);
            end

            if (r_state == S_OUT) begin
                if (w_rd_en) begin
                    r_rd_cnt <= r_rd_cnt + 5'd1;
                end
            end else begin
                r_rd_cnt <= 5'd0;
            end

            // Read data arrives one cycle after rd_en and is registered once
            // more, so out_valid trails rd_en by two cycles.
            r_rd_v1     <= w_rd_en;
            r_out_valid <= r_rd_v1;
            if (r_rd_v1) begin
                r_x_out <= rd_data;
            end
        end
    end

    assign b_we      = r_b_we;
    assign b_waddr   = r_b_waddr;
    assign b_wdata   = r_b_wdata;
    assign row_start = w_row_start;
    assign row_idx   = r_row_idx;
    assign nbr_mask  = r_nbr_mask;
    assign rd_en     = w_rd_en;
    assign rd_addr   = r_rd_cnt[3:0];
    assign out_valid = r_out_valid;
    assign x_out     = r_x_out;
    assign busy      = w_busy;
    assign sweep_cnt = r_sweep;

endmodule
`default_nettype wire

// File: tb/tb_gsim_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_gsim_sweep_ctrl
// Description : Self-checking bench for gsim_sweep_ctrl. Random b words,
//               random engine latency, per-sweep convergence tables and a
//               random x store; expected stop sweep, row order, masks and
//               result stream come from a plain behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gsim_sweep_ctrl;

    localparam int c_N    = 16;
    localparam int c_IT   = 64;
    localparam int c_MIN  = 8;
    localparam int c_DW   = 16;
    localparam int c_XW   = 32;
    localparam int c_ITW  = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_en;
    logic [c_DW-1:0]   b_in;
    logic              b_we;
    logic [3:0]        b_waddr;
    logic [c_DW-1:0]   b_wdata;
    logic              row_start;
    logic [3:0]        row_idx;
    logic [5:0]        nbr_mask;
    logic              row_done;
    logic              row_conv;
    logic              rd_en;
    logic [3:0]        rd_addr;
    logic [c_XW-1:0]   rd_data;
    logic              out_valid;
    logic [c_XW-1:0]   x_out;
    logic              busy;
    logic [c_ITW-1:0]  sweep_cnt;

    gsim_sweep_ctrl #(
        .N(c_N), .N_ITER(c_IT), .MIN_ITER(c_MIN), .DW(c_DW), .XW(c_XW), .ITW(c_ITW)
    ) dut (
        .clk(clk), .reset(reset), .in_en(in_en), .b_in(b_in),
        .b_we(b_we), .b_waddr(b_waddr), .b_wdata(b_wdata),
        .row_start(row_start), .row_idx(row_idx), .nbr_mask(nbr_mask),
        .row_done(row_done), .row_conv(row_conv),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .out_valid(out_valid), .x_out(x_out), .busy(busy), .sweep_cnt(sweep_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- reference model state ----------------
    bit              conv_tab [0:c_IT-1][0:c_N-1];
    logic [c_XW-1:0] xmem [0:c_N-1];
    int              exp_row;
    int              exp_sweep;
    int              cur_stop;
    int              epoch = 0;
    bit              eng_busy;

    typedef struct {
        int              addr;
        logic [c_DW-1:0] data;
        int              cyc;
    } bw_t;
    bw_t bq[$];

    function automatic logic [5:0] ref_mask(input int r);
        logic [5:0] m;
        for (int i = 0; i < 6; i++) begin
            int d;
            d    = (i < 3) ? i - 3 : i - 2;
            m[i] = (r + d >= 0) && (r + d <= c_N - 1);
        end
        return m;
    endfunction

    // First sweep s at which the run must end given the convergence table.
    function automatic int ref_stop();
        for (int s = 1; s <= c_IT; s++) begin
            bit all;
            all = 1'b1;
            for (int r = 0; r < c_N; r++) all = all & conv_tab[s-1][r];
            if (s == c_IT || (all && s >= c_MIN)) return s;
        end
        return c_IT;
    endfunction

    task automatic fill_tab(input int mode, input int from_s);
        for (int s = 0; s < c_IT; s++)
            for (int r = 0; r < c_N; r++)
                case (mode)
                    0: conv_tab[s][r] = 1'b0;
                    1: conv_tab[s][r] = 1'b1;
                    2: conv_tab[s][r] = (s >= from_s);
                    default: conv_tab[s][r] = (s >= from_s) && ($urandom_range(0, 15) != 0);
                endcase
    endtask

    task automatic fill_x();
        for (int k = 0; k < c_N; k++) xmem[k] = $urandom;
    endtask

    // ---------------- b store write monitor ----------------
    initial begin : mon_b
        bw_t e;
        bit  exp_we;
        forever begin
            @(negedge clk);
            exp_we = (bq.size() > 0) && (bq[0].cyc + 1 == cyc);
            check("b_we", 64'(b_we), 64'(exp_we));
            if (exp_we) begin
                e = bq.pop_front();
                check("b_waddr", 64'(b_waddr), 64'(e.addr));
                check("b_wdata", 64'(b_wdata), 64'(e.data));
            end
        end
    end

    // ---------------- x store model (1-cycle read latency) ----------------
    initial begin : xstore
        bit         pv;
        logic [3:0] pa;
        pv = 1'b0;
        pa = 4'd0;
        rd_data = '0;
        forever begin
            @(negedge clk);
            rd_data = pv ? xmem[pa] : c_XW'($urandom);
            pv = rd_en;
            pa = rd_addr;
        end
    end

    // ---------------- row-update engine model ----------------
    initial begin : engine
        int s, r, lat, ep;
        row_done = 1'b0;
        row_conv = 1'b0;
        eng_busy = 1'b0;
        forever begin
            @(negedge clk);
            while (row_start && !reset) begin
                eng_busy = 1'b1;
                ep = epoch;
                check("row_idx", 64'(row_idx), 64'(exp_row));
                check("nbr_mask", 64'(nbr_mask), 64'(ref_mask(exp_row)));
                check("extra_row", 64'(exp_sweep < cur_stop), 64'(1));
                s = exp_sweep;
                r = exp_row;
                if (exp_row == c_N - 1) begin
                    exp_row = 0;
                    exp_sweep++;
                end else begin
                    exp_row++;
                end
                lat = $urandom_range(0, 2);
                repeat (lat + 1) begin
                    @(negedge clk);
                    if (epoch == ep) begin
                        check("row_start_pulse", 64'(row_start), 64'(0));
                        check("row_hold", 64'(row_idx), 64'(r));
                    end
                end
                row_conv = (s < c_IT) ? conv_tab[s][r] : 1'b0;
                row_done = 1'b1;
                @(negedge clk);
                row_done = 1'b0;
                row_conv = 1'b0;
                eng_busy = 1'b0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic chk_zero(input string pfx);
        check({pfx, "_b_we"},      64'(b_we),      64'(0));
        check({pfx, "_b_waddr"},   64'(b_waddr),   64'(0));
        check({pfx, "_b_wdata"},   64'(b_wdata),   64'(0));
        check({pfx, "_row_start"}, 64'(row_start), 64'(0));
        check({pfx, "_row_idx"},   64'(row_idx),   64'(0));
        check({pfx, "_nbr_mask"},  64'(nbr_mask),  64'(0));
        check({pfx, "_rd_en"},     64'(rd_en),     64'(0));
        check({pfx, "_rd_addr"},   64'(rd_addr),   64'(0));
        check({pfx, "_out_valid"}, 64'(out_valid), 64'(0));
        check({pfx, "_x_out"},     64'(x_out),     64'(0));
        check({pfx, "_busy"},      64'(busy),      64'(0));
        check({pfx, "_sweep_cnt"}, 64'(sweep_cnt), 64'(0));
    endtask

    // mode 0: back-to-back, 1: 3 idle cycles after word 5, 2: random gaps
    task automatic load_b(input int mode);
        bw_t e;
        for (int k = 0; k < c_N; k++) begin
            int g;
            g = 0;
            if (mode == 1 && k == 6) g = 3;
            else if (mode == 2) g = $urandom_range(0, 2);
            repeat (g) begin
                in_en = 1'b0;
                b_in  = c_DW'($urandom);
                @(negedge clk);
            end
            in_en  = 1'b1;
            b_in   = c_DW'($urandom);
            e.addr = k;
            e.data = b_in;
            e.cyc  = cyc;
            bq.push_back(e);
            @(negedge clk);
        end
        in_en = 1'b0;
    endtask

    task automatic run_case(input string name, input int mode, input bit do_reset);
        bit found;
        cur_stop  = ref_stop();
        exp_row   = 0;
        exp_sweep = 0;
        fill_x();
        load_b(mode);
        found = 1'b0;
        for (int n = 0; n < 20000; n++) begin
            if (do_reset ? (exp_sweep == 3 && exp_row >= 2 && eng_busy && !row_start) : rd_en) begin
                found = 1'b1;
                break;
            end
            // stray b words while the solver runs must be dropped
            in_en = ($urandom_range(0, 3) == 0);
            b_in  = c_DW'($urandom);
            @(negedge clk);
        end
        in_en = 1'b0;
        check({name, "_reached"}, 64'(found), 64'(1));
        if (!found) return;

        if (do_reset) begin
            check({name, "_pre_rst_sweep"}, 64'(sweep_cnt), 64'(3));
            check({name, "_pre_rst_busy"},  64'(busy),      64'(1));
            reset = 1'b1;
            epoch++;
            @(negedge clk);
            chk_zero({name, "_rst"});
            reset     = 1'b0;
            exp_row   = 0;
            exp_sweep = 0;
            return;
        end

        check({name, "_sweep_cnt"},   64'(sweep_cnt), 64'(cur_stop));
        check({name, "_rows_issued"}, 64'(exp_sweep * c_N + exp_row), 64'(cur_stop * c_N));
        for (int i = 0; i < 20; i++) begin
            check({name, "_rd_en"}, 64'(rd_en), 64'(i < c_N));
            if (i < c_N) check({name, "_rd_addr"}, 64'(rd_addr), 64'(i));
            check({name, "_out_valid"}, 64'(out_valid), 64'(i >= 2 && i < c_N + 2));
            if (i >= 2 && i < c_N + 2) check({name, "_x_out"}, 64'(x_out), 64'(xmem[i-2]));
            check({name, "_busy"}, 64'(busy), 64'(i < 19));
            if (i == 19) check({name, "_sweep_hold"}, 64'(sweep_cnt), 64'(cur_stop));
            if (i < 19) begin
                in_en = ($urandom_range(0, 2) == 0);
                b_in  = c_DW'($urandom);
                @(negedge clk);
            end else begin
                in_en = 1'b0;
            end
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        reset = 1'b1;
        in_en = 1'b0;
        b_in  = '0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        reset = 1'b0;

        fill_tab(0, 0);
        run_case("cap64", 0, 1'b0);

        fill_tab(1, 0);
        run_case("conv8", 2, 1'b0);

        fill_tab(2, 19);
        run_case("conv20", 2, 1'b0);

        fill_tab(1, 0);
        conv_tab[7][7] = 1'b0;
        run_case("oneoff", 1, 1'b0);

        fill_tab(3, 4);
        run_case("midrst", 2, 1'b1);

        fill_tab(3, 10);
        run_case("rnd", 2, 1'b0);

        fill_tab(1, 0);
        run_case("after_rnd", 0, 1'b0);

        repeat (3) @(negedge clk);
        check("bq_empty", 64'(bq.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
